prbs15_pattern_gen: RTL and testbench
=====================================

// Module: prbs15_pattern_gen
// PURPOSE
//  Transmit end of the PRBS-15 link; drives the byte stream the pattern detector consumes.
//  Sends a loaded 4-byte pattern n_repeat times, then free-running PRBS-15 bytes, one byte per clk while active.
//  Sits between the config/control register block and the serializer or pattern-detector input.
// PARAMETERS
//  DATA_W   8     output byte width; 8 is the only supported value
//  N_W      8     width of n_repeat
//  PAT_LEN  4     bytes per pattern; fixed at 4
// PORTS
//  clk           in   1      single clock, rising edge
//  rst           in   1      asynchronous, active-low reset (0 = reset)
//  start         in   1      1-cycle pulse; sampled only in IDLE
//  stop          in   1      level; return to IDLE at next edge, any state
//  pattern       in   32     {b3,b2,b1,b0}; b0 sent first; captured on start
//  n_repeat      in   N_W    pattern repetitions; captured on start
//  out_PRBS      out  8      output byte
//  out_valid     out  1      out_PRBS is valid this cycle
//  pattern_done  out  1      1-cycle pulse with the first PRBS byte
//  busy          out  1      high in PATTERN or PRBS
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, out_PRBS=0, out_valid=0, pattern_done=0, busy=0, LFSR=0, counters=0.
//  All outputs are registered.
//  FSM IDLE -> PATTERN on start if n_repeat!=0. IDLE -> PRBS on start if n_repeat==0, with pattern_done pulsed.
//  FSM PATTERN -> PRBS after byte b3 of repetition n_repeat. PRBS runs until stop.
//  Latency: start at edge k -> first byte valid after edge k+1.
//  PATTERN: 2-bit byte index 0..3 wraps; the repetition counter increments on wrap.
//  PATTERN: b0,b1,b2,b3 are emitted back-to-back, with no gap between repetitions.
//  LFSR seed is set on start: seed = {b1[6:0],b0}. If the seed is 0, 15'h7FFF is used instead.
//  LFSR polynomial is x^15+x^14+1 (Fibonacci): fb=s[14]^s[13]; s<={s[13:0],fb}.
//  Each PRBS byte = 8 successive fb bits; the first bit goes to out_PRBS[7]. The LFSR advances 8 steps per byte.
//  There is no gap between the last pattern byte and the first PRBS byte.
//  stop has priority over start and over all state transitions. The next edge gives IDLE, out_valid=0, busy=0.
//  stop leaves out_PRBS holding its last value.
//  start while busy is ignored. pattern and n_repeat changes while busy are ignored (captured copies are used).
//  rst asserted mid-stream aborts immediately to the reset values. No partial byte is flagged valid.
//  The LFSR never reaches all-zero, because the seed is guarded.
// CONFIGURATION
//  Macro ERR_INJECT_EN:
//   Defined: adds input err_inject (1 bit). A pulse in PRBS state XORs bit 0 of the next emitted byte.
//            LFSR state is unaffected; used to exercise the detector's error path.
//            In PATTERN/IDLE the pulse is dropped.
//   Undefined: port absent; bytes are always unmodified.
// STRUCTURE
//  Package prbs15_pkg: state enum {IDLE,PATTERN,PRBS}; constants POLY_TAP_HI=14, POLY_TAP_LO=13;
//   LFSR_W=15; SEED_ZERO_SUB=15'h7FFF; function prbs15_step8(s) -> {next_state, byte}.
//  Sub-module prbs15_lfsr_byte: seed load, 8-step advance per enable, byte output.
//   It is shared with the receiver-side checker.
//  Top: FSM, byte/repetition counters, output mux/registers.
// TESTING
//  1 pattern=32'h23EFCDAB, n_repeat=2, start
//    -> AB CD EF 23 AB CD EF 23, then 0xAD, with pattern_done on the 0xAD cycle.
//  2 n_repeat=0, start -> first valid byte is 0xAD (same seed), pattern_done on that cycle.
//    Pattern bytes are never emitted.
//  3 Seed guard: pattern=32'h00000000, n_repeat=1 -> 00 00 00 00, then LFSR from 7FFF.
//    Scoreboard vs model; no zero lock-up over 32767 bytes; period = 32767 bits.
//  4 stop during 2nd repetition at byte CD -> next edge out_valid=0, busy=0.
//    A new start restarts from b0 with the fresh n_repeat.
//  5 rst pulled low mid-PRBS asynchronously -> outputs take reset values before the next clk edge.
//    start during busy is ignored: the sequence is unchanged.
//  6 ERR_INJECT_EN defined: err_inject in PRBS -> exactly one byte differs from the model, by bit 0.
//    Following bytes match the model. Loopback into the detector with n_detec=2 raises its flag.

Source files
------------

// File: rtl/prbs15_pkg.sv
// rtl/prbs15_pkg.sv - shared types, constants and byte-step function for the PRBS-15 link
// Purpose: FSM state encoding, LFSR constants and the 8-step Fibonacci LFSR
//          advance used by both the pattern generator and the receive-side checker.
// Ports:   none (package)
package prbs15_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PATTERN = 2'd1,
        PRBS    = 2'd2
    } state_t;

    localparam int POLY_TAP_HI = 14;
    localparam int POLY_TAP_LO = 13;
    localparam int LFSR_W      = 15;

    localparam logic [LFSR_W-1:0] SEED_ZERO_SUB = 15'h7FFF;

    // Advances the x^15+x^14+1 Fibonacci LFSR eight times.
    // Returns {state after 8 steps, byte}; the first feedback bit lands in byte[7].
    function automatic logic [LFSR_W+7:0] prbs15_step8(input logic [LFSR_W-1:0] s);
        logic [LFSR_W-1:0] st;
        logic [7:0]        b;
        logic              fb;
        st = s;
        b  = '0;
        for (int i = 0; i < 8; i++) begin
            fb = st[POLY_TAP_HI] ^ st[POLY_TAP_LO];
            st = {st[LFSR_W-2:0], fb};
            b  = {b[6:0], fb};
        end
        return {st, b};
    endfunction

endpackage

// File: rtl/prbs15_lfsr_byte.sv
// rtl/prbs15_lfsr_byte.sv - PRBS-15 LFSR producing one byte per advance
// Purpose: holds the 15-bit LFSR state; loads a seed (zero seed replaced by
//          SEED_ZERO_SUB so the register can never lock up at all-zero) and
//          steps 8 bits per enable. o_byte is the byte the next advance emits.
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset (state cleared to 0)
//   i_load   in   load seed this edge (has priority over i_adv)
//   i_seed   in   15-bit seed
//   i_adv    in   advance 8 steps this edge
//   o_byte   out  byte produced from the current state
import prbs15_pkg::*;

module prbs15_lfsr_byte (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic [LFSR_W-1:0] i_seed,
    input  logic              i_adv,
    output logic [7:0]        o_byte
);

    logic [LFSR_W-1:0] r_state;
    logic [LFSR_W+7:0] w_step;
    logic [LFSR_W-1:0] w_next;

    assign w_step = prbs15_step8(r_state);
    assign w_next = w_step[LFSR_W+7:8];
    assign o_byte = w_step[7:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= '0;
        end else if (i_load) begin
            r_state <= (i_seed == '0) ? SEED_ZERO_SUB : i_seed;
        end else if (i_adv) begin
            r_state <= w_next;
        end
    end

endmodule

// File: rtl/prbs15_pattern_gen.sv
// rtl/prbs15_pattern_gen.sv - PRBS-15 transmit pattern generator
// Purpose: on start, sends the captured 4-byte pattern n_repeat times (b0 first,
//          back-to-back), then free-running PRBS-15 bytes until stop. All outputs
//          are registered; first byte is valid one edge after the start edge.
// Optional: ERR_INJECT_EN adds input err_inject, which flips bit 0 of the byte
//           emitted on the edge it is sampled in PRBS state (LFSR unaffected).
// Ports:
//   clk           in   clock, rising edge
//   rst           in   asynchronous active-low reset
//   start         in   1-cycle start pulse, honoured only in IDLE
//   stop          in   level; forces IDLE on the next edge from any state
//   pattern       in   {b3,b2,b1,b0}, captured on start
//   n_repeat      in   pattern repetitions, captured on start
//   err_inject    in   (ERR_INJECT_EN only) single-byte bit-0 error request
//   out_PRBS      out  output byte (held when not emitting)
//   out_valid     out  out_PRBS valid this cycle
//   pattern_done  out  pulse alongside the first PRBS byte
//   busy          out  high in PATTERN or PRBS
import prbs15_pkg::*;

module prbs15_pattern_gen #(
    parameter int DATA_W  = 8,
    parameter int N_W     = 8,
    parameter int PAT_LEN = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      stop,
    input  logic [PAT_LEN*DATA_W-1:0] pattern,
    input  logic [N_W-1:0]            n_repeat,
`ifdef ERR_INJECT_EN
    input  logic                      err_inject,
`endif
    output logic [DATA_W-1:0]         out_PRBS,
    output logic                      out_valid,
    output logic                      pattern_done,
    output logic                      busy
);

    localparam int IDX_W = $clog2(PAT_LEN);

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [PAT_LEN*DATA_W-1:0] r_pat;
    logic [N_W-1:0]            r_nrep;
    logic [N_W-1:0]            r_rep;
    logic [IDX_W-1:0]          r_idx;
    logic                      r_first;

    logic                      w_load;
    logic                      w_adv;
    logic                      w_emit_pat;
    logic                      w_emit_prbs;
    logic                      w_wrap;
    logic                      w_last_rep;
    logic                      w_err_bit;
    logic [7:0]                w_lfsr_byte;

    assign w_wrap     = (r_idx == IDX_W'(PAT_LEN - 1));
    assign w_last_rep = (r_rep == (r_nrep - N_W'(1)));

`ifdef ERR_INJECT_EN
    assign w_err_bit = err_inject;
`else
    assign w_err_bit = 1'b0;
`endif

    prbs15_lfsr_byte u_lfsr (
        .clk    (clk),
        .rst_n  (rst),
        .i_load (w_load),
        .i_seed (pattern[LFSR_W-1:0]),
        .i_adv  (w_adv),
        .o_byte (w_lfsr_byte)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_adv       = 1'b0;
        w_emit_pat  = 1'b0;
        w_emit_prbs = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_state_nxt = (n_repeat == '0) ? PRBS : PATTERN;
                end
            end
            PATTERN: begin
                w_emit_pat = 1'b1;
                if (w_wrap && w_last_rep) begin
                    w_state_nxt = PRBS;
                end
            end
            PRBS: begin
                w_emit_prbs = 1'b1;
                w_adv       = 1'b1;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        // stop overrides everything, including a start seen in IDLE
        if (stop) begin
            w_state_nxt = IDLE;
            w_load      = 1'b0;
            w_adv       = 1'b0;
            w_emit_pat  = 1'b0;
            w_emit_prbs = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pat   <= '0;
            r_nrep  <= '0;
            r_rep   <= '0;
            r_idx   <= '0;
            r_first <= 1'b0;
        end else begin
            // Marks the edge on which PRBS is entered so the following byte carries pattern_done
            r_first <= (w_state_nxt == PRBS) && (r_state != PRBS);
            if (w_load) begin
                r_pat  <= pattern;
                r_nrep <= n_repeat;
                r_rep  <= '0;
                r_idx  <= '0;
            end else if (w_emit_pat) begin
                r_idx <= r_idx + IDX_W'(1);
                if (w_wrap) begin
                    r_rep <= r_rep + N_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_PRBS     <= '0;
            out_valid    <= 1'b0;
            pattern_done <= 1'b0;
            busy         <= 1'b0;
        end else begin
            out_valid    <= w_emit_pat | w_emit_prbs;
            pattern_done <= w_emit_prbs & r_first;
            busy         <= (w_state_nxt != IDLE);
            if (w_emit_pat) begin
                out_PRBS <= r_pat[r_idx*DATA_W +: DATA_W];
            end else if (w_emit_prbs) begin
                out_PRBS <= w_lfsr_byte ^ {{(DATA_W-1){1'b0}}, w_err_bit};
            end
        end
    end

endmodule

// File: tb/tb_prbs15_pattern_gen.sv
// tb/tb_prbs15_pattern_gen.sv - self-checking bench for prbs15_pattern_gen
module tb_prbs15_pattern_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        stop;
    logic [31:0] pattern;
    logic [7:0]  n_repeat;
    logic [7:0]  out_PRBS;
    logic        out_valid;
    logic        pattern_done;
    logic        busy;
`ifdef ERR_INJECT_EN
    logic        err_inject;
`endif

    int checks = 0;
    int errors = 0;

    // Reference bit history, oldest bit at index 0 (the last 15 generated bits)
    bit mq[$];

    always #5 clk = ~clk;

    prbs15_pattern_gen dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .stop         (stop),
        .pattern      (pattern),
        .n_repeat     (n_repeat),
`ifdef ERR_INJECT_EN
        .err_inject   (err_inject),
`endif
        .out_PRBS     (out_PRBS),
        .out_valid    (out_valid),
        .pattern_done (pattern_done),
        .busy         (busy)
    );

    typedef struct {
        logic [31:0] pat;
        logic [7:0]  nrep;
        int          nprbs;
        bit          chk_first;
        logic [7:0]  exp_first;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Sequence rule: each new bit is the XOR of the bits generated 15 and 14 bits ago
    task automatic model_seed(input logic [31:0] pat);
        logic [14:0] s;
        s = pat[14:0];
        if (s == 15'd0) s = 15'h7FFF;
        mq.delete();
        for (int i = 14; i >= 0; i--) mq.push_back(s[i]);
    endtask

    task automatic model_byte(output logic [7:0] b);
        bit nb;
        b = 8'h00;
        for (int i = 0; i < 8; i++) begin
            nb = mq[0] ^ mq[1];
            mq.push_back(nb);
            void'(mq.pop_front());
            b = {b[6:0], nb};
        end
    endtask

    function automatic logic [7:0] pat_byte(input logic [31:0] pat, input int i);
        logic [31:0] sh;
        sh = pat >> (8 * (i % 4));
        return sh[7:0];
    endfunction

    task automatic do_start(input logic [31:0] pat, input logic [7:0] n);
        @(negedge clk);
        pattern  = pat;
        n_repeat = n;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_gap_valid", out_valid, 1'b0);
        chk("start_gap_busy", busy, 1'b1);
    endtask

    task automatic do_stop(input logic [7:0] last);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("stop_valid", out_valid, 1'b0);
        chk("stop_busy", busy, 1'b0);
        chk("stop_hold", out_PRBS, last);
        chk("stop_pdone", pattern_done, 1'b0);
    endtask

    task automatic run_stream(input vec_t v);
        logic [7:0] exp;
        int         npat;
        npat = int'(v.nrep) * 4;
        do_start(v.pat, v.nrep);
        model_seed(v.pat);
        for (int i = 0; i < npat + v.nprbs; i++) begin
            @(negedge clk);
            if (i < npat) exp = pat_byte(v.pat, i);
            else          model_byte(exp);
            chk("byte", out_PRBS, exp);
            chk("valid", out_valid, 1'b1);
            chk("busy", busy, 1'b1);
            chk("pattern_done", pattern_done, (i == npat));
            if (i == npat && v.chk_first) chk("first_prbs_byte", out_PRBS, v.exp_first);
            // start and input changes while busy must not disturb the sequence
            if (i == 1) begin
                pattern  = ~v.pat;
                n_repeat = v.nrep + 8'd5;
                start    = 1'b1;
            end
            if (i == 2) start = 1'b0;
        end
        do_stop(exp);
    endtask

    vec_t vecs[7];

    initial begin
        logic [7:0] exp;
        logic [7:0] first_b;
        logic [7:0] prev_b;
        int         dbl_zero;

        vecs[0] = '{32'h23EFCDAB, 8'd2, 4,  1'b1, 8'hAD};
        vecs[1] = '{32'h23EFCDAB, 8'd0, 6,  1'b1, 8'hAD};
        vecs[2] = '{32'h00004000, 8'd1, 5,  1'b1, 8'h80};
        vecs[3] = '{32'h00006000, 8'd3, 5,  1'b1, 8'h40};
        for (int k = 4; k < 7; k++) begin
            vecs[k] = '{$urandom, 8'($urandom_range(0, 3)), 8, 1'b0, 8'h00};
        end

        rst      = 1'b0;
        start    = 1'b0;
        stop     = 1'b0;
        pattern  = 32'h0;
        n_repeat = 8'd0;
`ifdef ERR_INJECT_EN
        err_inject = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_out", out_PRBS, 8'h00);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_pdone", pattern_done, 1'b0);
        chk("rst_busy", busy, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_valid", out_valid, 1'b0);

        for (int k = 0; k < 7; k++) run_stream(vecs[k]);

        // stop during the 2nd repetition at byte CD, then restart with fresh settings
        do_start(32'h23EFCDAB, 8'd3);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("stop_seq_byte", out_PRBS, pat_byte(32'h23EFCDAB, i));
        end
        do_stop(8'hCD);
        run_stream('{32'h44332211, 8'd1, 6, 1'b0, 8'h00});

        // asynchronous reset mid-PRBS
        do_start(32'h23EFCDAB, 8'd0);
        repeat (5) @(negedge clk);
        chk("pre_rst_valid", out_valid, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_out", out_PRBS, 8'h00);
        chk("async_rst_valid", out_valid, 1'b0);
        chk("async_rst_busy", busy, 1'b0);
        chk("async_rst_pdone", pattern_done, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_valid", out_valid, 1'b0);
        run_stream(vecs[0]);

        // seed guard and full period from 7FFF
        do_start(32'h00000000, 8'd1);
        model_seed(32'h00000000);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("zero_pat_byte", out_PRBS, 8'h00);
        end
        dbl_zero = 0;
        prev_b   = 8'hFF;
        first_b  = 8'h00;
        for (int i = 0; i < 32768; i++) begin
            @(negedge clk);
            model_byte(exp);
            chk("long_byte", out_PRBS, exp);
            if (i == 0) first_b = out_PRBS;
            if (out_PRBS == 8'h00 && prev_b == 8'h00) dbl_zero++;
            prev_b = out_PRBS;
            if (i == 32767) chk("period_32767", out_PRBS, first_b);
        end
        chk("no_lockup", dbl_zero, 0);
        do_stop(exp);

`ifdef ERR_INJECT_EN
        do_start(32'h23EFCDAB, 8'd0);
        model_seed(32'h23EFCDAB);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            model_byte(exp);
            chk("err_byte", out_PRBS, (i == 3) ? (exp ^ 8'h01) : exp);
            err_inject = (i == 2);
        end
        err_inject = 1'b0;
        do_stop(exp);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
